// File: rtl/rc4_ksa_ctrl_if.sv
// S-box SRAM port bundle for the RC4 key-scheduling controller.
// master: the controller driving address/strobes; slave: the SRAM model/macro.
interface rc4_ksa_ctrl_if;
    logic [7:0] sram_addr_o;
    logic       sram_re_o;
    logic [7:0] sram_rdata_i;
    logic       sram_we_o;
    logic [7:0] sram_wdata_o;

    modport master (
        output sram_addr_o,
        output sram_re_o,
        output sram_we_o,
        output sram_wdata_o,
        input  sram_rdata_i
    );

    modport slave (
        input  sram_addr_o,
        input  sram_re_o,
        input  sram_we_o,
        input  sram_wdata_o,
        output sram_rdata_i
    );
endinterface

// File: rtl/rc4_ksa_ctrl.sv
// RC4 key-scheduling algorithm (KSA) controller.
// Walks a 256-byte S-box held in an external single-port SRAM with a
// one-cycle read latency: optional identity fill (INIT), then 256
// iterations of read S[i], read S[j'], write S[i], write S[j] (4 cycles each).
// Each new j is offered on locEnd_o with a one-cycle store_loc_o strobe.
// Build option: define KSA_INIT_BYPASS_EN to drop the INIT phase when the
// S-box is already known to hold the identity permutation.
module rc4_ksa_ctrl (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [5:0]            key_len_i,
    output logic [4:0]            key_addr_o,
    input  logic [7:0]            key_byte_i,
    rc4_ksa_ctrl_if.master        sram,
    output logic [7:0]            locEnd_o,
    output logic                  store_loc_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_RD_I,
        S_RD_J,
        S_WR_I,
        S_WR_J,
        S_DONE
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] i_q;
    logic [7:0] j_q;
    logic [4:0] k_q;
    logic [7:0] si_q;
    logic [5:0] len_q;
    logic       err_q;

    logic       start_ok;
    logic       k_last;
    logic [7:0] j_next;

    // A legal start request; start_i is only honoured in IDLE.
    assign start_ok = start_i && (key_len_i != 6'd0);
    // k wraps on the latched length so key_len_i may change mid-run.
    assign k_last   = ({1'b0, k_q} == (len_q - 6'd1));
    // S[i] arrives from the RD_I read during RD_J; sum wraps modulo 256.
    assign j_next   = j_q + sram.sram_rdata_i + key_byte_i;

    assign key_addr_o = k_q;
    assign err_o      = err_q;

    // State register and datapath registers (i, j, k, si, latched length).
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the clock edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            i_q     <= 8'd0;
            j_q     <= 8'd0;
            k_q     <= 5'd0;
            si_q    <= 8'd0;
            len_q   <= 6'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= (state_q == S_IDLE) && start_i && (key_len_i == 6'd0);
            case (state_q)
                S_IDLE: begin
                    if (start_ok) begin
                        len_q <= key_len_i;
                        i_q   <= 8'd0;
                        j_q   <= 8'd0;
                        k_q   <= 5'd0;
                    end
                end
                S_INIT: begin
                    // Wraps 255 -> 0, which leaves i cleared for RD_I.
                    i_q <= i_q + 8'd1;
                end
                S_RD_J: begin
                    si_q <= sram.sram_rdata_i;
                    j_q  <= j_next;
                end
                S_WR_J: begin
                    if (i_q != 8'd255) begin
                        i_q <= i_q + 8'd1;
                        k_q <= k_last ? 5'd0 : (k_q + 5'd1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Next-state decode and SRAM / locSafe strobes for the current state.
    // NOTE: every signal written here is given a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d           = state_q;
        sram.sram_addr_o  = 8'd0;
        sram.sram_re_o    = 1'b0;
        sram.sram_we_o    = 1'b0;
        sram.sram_wdata_o = 8'd0;
        locEnd_o          = 8'd0;
        store_loc_o       = 1'b0;
        busy_o            = 1'b1;
        done_o            = 1'b0;
        case (state_q)
            S_IDLE: begin
                busy_o = 1'b0;
                if (start_ok) begin
`ifdef KSA_INIT_BYPASS_EN
                    state_d = S_RD_I;
`else
                    state_d = S_INIT;
`endif
                end
            end
            S_INIT: begin
                sram.sram_we_o    = 1'b1;
                sram.sram_addr_o  = i_q;
                sram.sram_wdata_o = i_q;
                if (i_q == 8'd255) state_d = S_RD_I;
            end
            S_RD_I: begin
                sram.sram_re_o   = 1'b1;
                sram.sram_addr_o = i_q;
                state_d          = S_RD_J;
            end
            S_RD_J: begin
                locEnd_o         = j_next;
                store_loc_o      = 1'b1;
                sram.sram_re_o   = 1'b1;
                sram.sram_addr_o = j_next;
                state_d          = S_WR_I;
            end
            S_WR_I: begin
                // S[j] is on the read bus this cycle and is written straight
                // back to S[i]; it is never needed again, so it is not held.
                sram.sram_we_o    = 1'b1;
                sram.sram_addr_o  = i_q;
                sram.sram_wdata_o = sram.sram_rdata_i;
                state_d           = S_WR_J;
            end
            S_WR_J: begin
                // With i == j both writes still happen; the second rewrites
                // the same original S[i] value, so the S-box stays correct.
                sram.sram_we_o    = 1'b1;
                sram.sram_addr_o  = j_q;
                sram.sram_wdata_o = si_q;
                state_d           = (i_q == 8'd255) ? S_DONE : S_RD_I;
            end
            S_DONE: begin
                done_o  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_rc4_ksa_ctrl.sv
// Directed testbench for rc4_ksa_ctrl: SRAM and key ROM models, reference
// RC4 KSA model, plus the published "Key" keystream (EB 9F 77 81 B7 34 CA 72 A7).
module tb_rc4_ksa_ctrl;

`ifdef KSA_INIT_BYPASS_EN
    localparam int EXP_DONE    = 1025;
    localparam int EXP_INIT_WR = 0;
    localparam int EXP_TOT_WR  = 512;
`else
    localparam int EXP_DONE    = 1281;
    localparam int EXP_INIT_WR = 256;
    localparam int EXP_TOT_WR  = 768;
`endif
    localparam int RUN_CYCLES  = 1400;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_i;
    logic [5:0] key_len_i;
    logic [4:0] key_addr_o;
    logic [7:0] key_byte_i;
    logic [7:0] locEnd_o;
    logic       store_loc_o;
    logic       busy_o;
    logic       done_o;
    logic       err_o;

    rc4_ksa_ctrl_if sram_bus ();

    rc4_ksa_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .key_len_i   (key_len_i),
        .key_addr_o  (key_addr_o),
        .key_byte_i  (key_byte_i),
        .sram        (sram_bus),
        .locEnd_o    (locEnd_o),
        .store_loc_o (store_loc_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_o       (err_o)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] mem     [256];
    logic [7:0] exp_s   [256];
    logic [7:0] key_mem [32];
    logic [7:0] ks_ref  [9];
    logic       preload_req = 1'b0;

    // Key ROM: combinational read.
    assign key_byte_i = key_mem[key_addr_o];

    // S-box SRAM: one-cycle read latency; preload fills it while idle.
    always @(posedge clk) begin
        if (preload_req) begin
            for (int a = 0; a < 256; a++) begin
`ifdef KSA_INIT_BYPASS_EN
                mem[a] <= 8'(a);
`else
                mem[a] <= ~8'(a);
`endif
            end
        end else begin
            if (sram_bus.sram_we_o) mem[sram_bus.sram_addr_o] <= sram_bus.sram_wdata_o;
            if (sram_bus.sram_re_o) sram_bus.sram_rdata_i <= mem[sram_bus.sram_addr_o];
        end
    end

    // Reference KSA for the key "Key".
    task automatic build_model();
        logic [7:0] s [256];
        logic [7:0] j, t;
        for (int a = 0; a < 256; a++) s[a] = 8'(a);
        j = 8'd0;
        for (int a = 0; a < 256; a++) begin
            j = j + s[a] + key_mem[a % 3];
            t = s[a]; s[a] = s[j]; s[j] = t;
        end
        for (int a = 0; a < 256; a++) exp_s[a] = s[a];
    endtask

    // Counts S-box bytes differing from the model, and keystream bytes
    // (RC4 PRGA run on the SRAM contents) differing from the published ones.
    task automatic eval_sbox(output int bad_s, output int bad_ks);
        logic [7:0] s [256];
        logic [7:0] i, j, t;
        bad_s = 0; bad_ks = 0;
        for (int a = 0; a < 256; a++) begin
            s[a] = mem[a];
            if (mem[a] !== exp_s[a]) bad_s++;
        end
        i = 8'd0; j = 8'd0;
        for (int n = 0; n < 9; n++) begin
            i = i + 8'd1;
            j = j + s[i];
            t = s[i]; s[i] = s[j]; s[j] = t;
            if (s[8'(s[i] + s[j])] !== ks_ref[n]) bad_ks++;
        end
    endtask

    // One run: preload, start, observe RUN_CYCLES cycles at the negedge.
    task automatic run_ksa(input logic [5:0] len, input int extra_start_cyc,
                           output int done_cyc, output int n_done,
                           output logic [7:0] first_loc, output int init_wr,
                           output int total_wr, output int viol, output int err_seen);
        bit seen_re = 0;
        bit got_loc = 0;
        done_cyc = -1; n_done = 0; first_loc = 8'h00;
        init_wr = 0; total_wr = 0; viol = 0; err_seen = 0;
        @(negedge clk); preload_req = 1'b1;
        @(posedge clk); #1 preload_req = 1'b0;
        @(negedge clk); start_i = 1'b1; key_len_i = len;
        @(posedge clk); #1 start_i = 1'b0;
        for (int cyc = 1; cyc <= RUN_CYCLES; cyc++) begin
            @(negedge clk);
            if (cyc == 10) key_len_i = 6'd7;
            start_i = (cyc == extra_start_cyc);
            if (done_o) begin
                n_done++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (store_loc_o && !got_loc) begin
                first_loc = locEnd_o;
                got_loc   = 1;
            end
            if (sram_bus.sram_we_o) begin
                total_wr++;
                if (!seen_re) init_wr++;
            end
            if (sram_bus.sram_re_o) seen_re = 1;
            if ((sram_bus.sram_re_o && sram_bus.sram_we_o) ||
                (sram_bus.sram_we_o && store_loc_o) ||
                (store_loc_o && !sram_bus.sram_re_o)) viol++;
            if (err_o) err_seen++;
        end
        start_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start_i = 1'b0; key_len_i = 6'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({busy_o, done_o, err_o, store_loc_o, sram_bus.sram_re_o, sram_bus.sram_we_o,
             sram_bus.sram_addr_o, sram_bus.sram_wdata_o, locEnd_o, key_addr_o} !== 35'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got busy=%b done=%b err=%b st=%b re=%b we=%b addr=%h wd=%h loc=%h ka=%h, expected all 0",
                     busy_o, done_o, err_o, store_loc_o, sram_bus.sram_re_o, sram_bus.sram_we_o,
                     sram_bus.sram_addr_o, sram_bus.sram_wdata_o, locEnd_o, key_addr_o);
        end
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (busy_o !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_busy: got %b expected 0", busy_o);
        end
    endtask

    task automatic test_known_key(input int extra_start_cyc, input string tag);
        int done_cyc, n_done, init_wr, total_wr, viol, err_seen, bad_s, bad_ks;
        logic [7:0] first_loc;
        run_ksa(6'd3, extra_start_cyc, done_cyc, n_done, first_loc, init_wr, total_wr, viol, err_seen);
        eval_sbox(bad_s, bad_ks);
        vectors++;
        if (first_loc !== 8'h4B) begin
            miscompares++;
            $display("FAIL %s first_locEnd: got %h expected 4b", tag, first_loc);
        end
        vectors++;
        if (done_cyc !== EXP_DONE) begin
            miscompares++;
            $display("FAIL %s done_cycle: got %0d expected %0d", tag, done_cyc, EXP_DONE);
        end
        vectors++;
        if (n_done !== 1) begin
            miscompares++;
            $display("FAIL %s done_count: got %0d expected 1", tag, n_done);
        end
        vectors++;
        if (init_wr !== EXP_INIT_WR) begin
            miscompares++;
            $display("FAIL %s init_writes: got %0d expected %0d", tag, init_wr, EXP_INIT_WR);
        end
        vectors++;
        if (total_wr !== EXP_TOT_WR) begin
            miscompares++;
            $display("FAIL %s total_writes: got %0d expected %0d", tag, total_wr, EXP_TOT_WR);
        end
        vectors++;
        if (viol !== 0) begin
            miscompares++;
            $display("FAIL %s strobe_overlap: got %0d cycles expected 0", tag, viol);
        end
        vectors++;
        if (err_seen !== 0) begin
            miscompares++;
            $display("FAIL %s err_during_run: got %0d expected 0", tag, err_seen);
        end
        vectors++;
        if (bad_s !== 0) begin
            miscompares++;
            $display("FAIL %s sbox_vs_model: got %0d bad bytes expected 0", tag, bad_s);
        end
        vectors++;
        if (bad_ks !== 0) begin
            miscompares++;
            $display("FAIL %s keystream: got %0d bad bytes expected 0", tag, bad_ks);
        end
        vectors++;
        if (busy_o !== 1'b0) begin
            miscompares++;
            $display("FAIL %s busy_after_done: got %b expected 0", tag, busy_o);
        end
    endtask

    task automatic test_zero_len();
        int strobes = 0;
        int busy_seen = 0;
        @(negedge clk); start_i = 1'b1; key_len_i = 6'd0;
        @(posedge clk); #1 start_i = 1'b0;
        @(negedge clk);
        vectors++;
        if (err_o !== 1'b1) begin
            miscompares++;
            $display("FAIL zero_len_err_pulse: got %b expected 1", err_o);
        end
        for (int cyc = 2; cyc <= 8; cyc++) begin
            @(negedge clk);
            if (cyc == 2) begin
                vectors++;
                if (err_o !== 1'b0) begin
                    miscompares++;
                    $display("FAIL zero_len_err_width: got %b expected 0", err_o);
                end
            end
            if (sram_bus.sram_re_o || sram_bus.sram_we_o || store_loc_o) strobes++;
            if (busy_o) busy_seen++;
        end
        vectors++;
        if (strobes !== 0 || busy_seen !== 0) begin
            miscompares++;
            $display("FAIL zero_len_idle: got strobes=%0d busy=%0d expected 0 and 0", strobes, busy_seen);
        end
    endtask

    task automatic test_abort();
        int done_seen = 0;
        @(negedge clk); preload_req = 1'b1;
        @(posedge clk); #1 preload_req = 1'b0;
        @(negedge clk); start_i = 1'b1; key_len_i = 6'd3;
        @(posedge clk); #1 start_i = 1'b0;
        for (int cyc = 1; cyc < 600; cyc++) begin
            @(negedge clk);
            if (done_o) done_seen++;
        end
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        vectors++;
        if ({busy_o, done_o, err_o, store_loc_o, sram_bus.sram_re_o, sram_bus.sram_we_o,
             sram_bus.sram_addr_o, sram_bus.sram_wdata_o, locEnd_o, key_addr_o} !== 35'd0) begin
            miscompares++;
            $display("FAIL abort_outputs: got busy=%b re=%b we=%b addr=%h loc=%h ka=%h, expected all 0",
                     busy_o, sram_bus.sram_re_o, sram_bus.sram_we_o, sram_bus.sram_addr_o, locEnd_o, key_addr_o);
        end
        rst = 1'b0;
        for (int cyc = 0; cyc < 900; cyc++) begin
            @(negedge clk);
            if (done_o) done_seen++;
        end
        vectors++;
        if (done_seen !== 0) begin
            miscompares++;
            $display("FAIL abort_no_done: got %0d done pulses expected 0", done_seen);
        end
        test_known_key(0, "restart");
    endtask

    initial begin
        key_mem[0] = 8'h4B; key_mem[1] = 8'h65; key_mem[2] = 8'h79;
        for (int a = 3; a < 32; a++) key_mem[a] = 8'hA5;
        ks_ref[0] = 8'hEB; ks_ref[1] = 8'h9F; ks_ref[2] = 8'h77;
        ks_ref[3] = 8'h81; ks_ref[4] = 8'hB7; ks_ref[5] = 8'h34;
        ks_ref[6] = 8'hCA; ks_ref[7] = 8'h72; ks_ref[8] = 8'hA7;
        build_model();

        test_reset();
        test_known_key(0, "known_key");
        test_zero_len();
        test_known_key(500, "busy_start");
        test_abort();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rc4_ksa_ctrl.md
RC4_KSA_CTRL -- requirements
Module: rc4_ksa_ctrl

Interface
REQ-001 SHALL provide: clk  in  1  system clock, rising edge active.
REQ-002 SHALL provide: rst  in  1  synchronous, active-high reset.
REQ-003 SHALL provide: start_i  in  1  request one KSA run; sampled only in IDLE.
REQ-004 SHALL provide: key_len_i  in  6  key length in bytes, legal 1..32; sampled with start_i.
REQ-005 SHALL provide: key_addr_o  out  5  index of current key byte, i mod key_len.
REQ-006 SHALL provide: key_byte_i  in  8  key byte at key_addr_o, combinationally valid in the same cycle.
REQ-007 SHALL provide: sram_addr_o  out  8  S-box address.
REQ-008 SHALL provide: sram_re_o  out  1  S-box read strobe; read data valid on sram_rdata_i the next cycle.
REQ-009 SHALL provide: sram_rdata_i  in  8  S-box read data.
REQ-010 SHALL provide: sram_we_o  out  1  S-box write strobe.
REQ-011 SHALL provide: sram_wdata_o  out  8  S-box write data.
REQ-012 SHALL provide: locEnd_o  out  8  new j value, for the downstream locSafe register.
REQ-013 SHALL provide: store_loc_o  out  1  one-cycle strobe telling locSafe to capture locEnd_o.
REQ-014 SHALL provide: busy_o  out  1  high in every state except IDLE.
REQ-015 SHALL provide: done_o  out  1  one-cycle pulse when a run completes.
REQ-016 SHALL provide: err_o  out  1  one-cycle pulse when start_i is sampled with key_len_i == 0.

Function
REQ-017 SHALL implement the FSM states IDLE, INIT, RD_I, RD_J, WR_I, WR_J, DONE.
REQ-018 IDLE with start_i=1 and key_len_i!=0 SHALL latch key_len_i, clear i, j and k, and go to INIT.
REQ-019 IDLE with start_i=1 and key_len_i==0 SHALL pulse err_o the next cycle and remain in IDLE.
REQ-020 INIT SHALL write S[i]=i (we=1, addr=wdata=i) for i=0..255, one write per cycle, then clear i and go to RD_I.
REQ-021 RD_I SHALL drive addr=i with re=1, then go to RD_J.
REQ-022 RD_J SHALL:
- latch si = sram_rdata_i;
- compute j' = (j + si + key_byte_i) mod 256 and register it as j;
- drive locEnd_o = j' with store_loc_o=1;
- drive addr=j' with re=1;
- then go to WR_I.
REQ-023 WR_I SHALL latch sj = sram_rdata_i, write S[i]=sj, then go to WR_J.
REQ-024 WR_J SHALL write S[j]=si; if i==255 go to DONE, else increment i and k and go to RD_I.
REQ-025 k SHALL wrap to 0 when it equals latched key_len-1; key_addr_o SHALL equal k.
REQ-026 All 8-bit arithmetic on i and j SHALL wrap modulo 256 with no overflow flag.
REQ-027 When i==j, WR_I and WR_J SHALL still issue both writes; the S-box contents remain correct.
REQ-028 DONE SHALL pulse done_o for exactly one cycle and return to IDLE.
REQ-029 Timing SHALL be fixed:
- each KSA iteration takes exactly 4 cycles;
- done_o SHALL assert 1281 cycles after the edge that samples start_i.
REQ-030 start_i SHALL be ignored while busy_o=1; changes to key_len_i during a run SHALL have no effect.
REQ-031 sram_re_o, sram_we_o and store_loc_o SHALL never be high in the same cycle except re with store_loc in RD_J.

Reset
REQ-032 While rst=1 at a clk edge, the FSM SHALL enter IDLE and clear i, j and k.
REQ-033 After reset, every output SHALL read 0: busy_o, done_o, err_o, store_loc_o, sram_re_o, sram_we_o, sram_addr_o, sram_wdata_o, locEnd_o and key_addr_o.
REQ-034 rst mid-run SHALL abort with no done_o; S-box contents are then undefined, and a later start_i SHALL run to completion normally.

Configuration
REQ-035 Macro KSA_INIT_BYPASS_EN SHALL control the INIT phase:
- undefined: INIT is present and timing is per REQ-029;
- defined: INIT is removed, IDLE goes directly to RD_I, no INIT writes occur, and done_o asserts 1025 cycles after start_i is sampled.

Verification
REQ-036 Reset check: assert rst for 2 cycles -> all outputs 0 and busy_o=0.
REQ-037 Known key: start with key_len=3, key 0x4B,0x65,0x79 ("Key") ->
- first store_loc_o shows locEnd_o=0x4B;
- done_o at cycle 1281;
- final S-box matches the software RC4 KSA model.
REQ-038 Zero length: start with key_len=0 -> err_o pulses for 1 cycle, busy_o stays 0, and no SRAM strobes occur.
REQ-039 Busy start: pulse start_i again at cycle 500 -> ignored, exactly one done_o, final S-box unchanged versus REQ-037.
REQ-040 Abort: assert rst at cycle 600 -> next cycle all outputs 0; a restart with the REQ-037 key matches REQ-037 results.
REQ-041 Bypass build: with KSA_INIT_BYPASS_EN and S preloaded with the identity -> done_o at cycle 1025, zero INIT writes, and S-box identical to REQ-037.
